// File: rtl/softmax_seq.sv
// softmax_seq: sequential softmax over ten logit exponents.
// Loads ten logits as powers of two, sums them, then asks a shared external
// divider for E[idx]/sum (Q16.16) once per class and streams the results.
// Optional macro SOFTMAX_SEQ_ARGMAX_EN adds an argmax tracker over the loaded
// logits; when undefined, argmax is tied to zero.
module softmax_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        div_start,
    output logic [47:0] div_num,
    output logic [35:0] div_den,
    input  logic        div_done,
    input  logic [31:0] div_quot,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic [3:0]  argmax
);

    typedef enum logic [2:0] {IDLE, LOAD, DIV_REQ, DIV_WAIT, OUT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  idx;
    logic [35:0] sum;
    logic [31:0] e_mem [10];
    logic [31:0] e_in;
    logic        beat;

    // 2^x with saturation at bit 31 for exponents that do not fit
    function automatic logic [31:0] clamp_exp(input logic [31:0] x);
        if (x < 32'd31)
            return 32'd1 << x[4:0];
        else
            return 32'h8000_0000;
    endfunction

    assign e_in      = clamp_exp(in_data);
    assign beat      = in_valid && in_ready;
    assign div_num   = {e_mem[idx], 16'h0000};
    assign div_den   = sum;
    assign out_idx   = idx;
    assign out_last  = out_valid && (idx == 4'd9);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode plus the state-derived handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        div_start = 1'b0;
        case (state)
            IDLE:     state_nxt = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (cnt == 4'd9))
                    state_nxt = DIV_REQ;
            end
            DIV_REQ: begin
                div_start = 1'b1;
                state_nxt = DIV_WAIT;
            end
            DIV_WAIT: begin
                if (div_done)
                    state_nxt = OUT;
            end
            OUT: begin
                if (out_ready)
                    state_nxt = (idx == 4'd9) ? LOAD : DIV_REQ;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // Logit storage; contents are only meaningful after a full load
    always_ff @(posedge clk) begin
        if (beat)
            e_mem[cnt] <= e_in;
    end

    // Counters, running sum and the output word register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            idx       <= 4'd0;
            sum       <= 36'd0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    sum <= 36'd0;
                end
                LOAD: begin
                    if (beat) begin
                        sum <= sum + {4'd0, e_in};
                        if (cnt == 4'd9) begin
                            cnt <= 4'd0;
                            idx <= 4'd0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                DIV_WAIT: begin
                    if (div_done) begin
                        out_data  <= div_quot;
                        out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == 4'd9) begin
                            idx <= 4'd0;
                            cnt <= 4'd0;
                            sum <= 36'd0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SOFTMAX_SEQ_ARGMAX_EN
    logic [31:0] max_val;
    logic [3:0]  max_idx;
    logic [3:0]  argmax_r;
    logic        take;
    logic [3:0]  max_idx_nxt;

    // The first beat always seeds the maximum; later beats need to be strictly larger
    assign take        = (cnt == 4'd0) || (e_in > max_val);
    assign max_idx_nxt = take ? cnt : max_idx;
    assign argmax      = argmax_r;

    // Running maximum during LOAD, published when the tenth beat lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val  <= 32'd0;
            max_idx  <= 4'd0;
            argmax_r <= 4'd0;
        end else if (beat) begin
            if (take)
                max_val <= e_in;
            max_idx <= max_idx_nxt;
            if (cnt == 4'd9)
                argmax_r <= max_idx_nxt;
        end
    end
`else
    assign argmax = 4'd0;
`endif

endmodule

// File: tb/tb_softmax_seq.sv
// Testbench for softmax_seq: directed logit sets with a 3-cycle divider model.
module tb_softmax_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        div_start;
    logic [47:0] div_num;
    logic [35:0] div_den;
    logic        div_done;
    logic [31:0] div_quot;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic [3:0]  argmax;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] logits   [10];
    logic [47:0] got_num  [10];
    logic [35:0] got_den  [10];
    logic [31:0] got_quot [10];
    logic [3:0]  got_arg;

    softmax_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .div_start (div_start),
        .div_num   (div_num),
        .div_den   (div_den),
        .div_done  (div_done),
        .div_quot  (div_quot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .argmax    (argmax)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_exp(input logic [31:0] x);
        if (x < 32'd31)
            return 32'd1 << x;
        else
            return 32'h8000_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},  in_ready,  0);
        chk({tag, "_div_start"}, div_start, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"},  out_data,  0);
        chk({tag, "_out_idx"},   out_idx,   0);
        chk({tag, "_out_last"},  out_last,  0);
        chk({tag, "_argmax"},    argmax,    0);
    endtask

    // Feed the ten logits in 'logits', then service all ten divide requests.
    // hold_idx: class whose output is back-pressured for 5 cycles (-1 = none).
    // rst_idx:  class during whose DIV_WAIT reset is pulsed (-1 = none).
    task automatic run_set(input int hold_idx, input int rst_idx);
        logic [31:0] e [10];
        logic [35:0] esum;
        logic [3:0]  amax;
        logic [47:0] num;
        logic [35:0] den;
        logic [47:0] q;
        logic [47:0] qexp;
        esum = 36'd0;
        amax = 4'd0;
        for (int i = 0; i < 10; i++) begin
            e[i] = ref_exp(logits[i]);
            esum = esum + {4'd0, e[i]};
            if (e[i] > e[amax])
                amax = i[3:0];
        end
`ifndef SOFTMAX_SEQ_ARGMAX_EN
        amax = 4'd0;
`endif
        for (int i = 0; i < 10; i++) begin
            chk("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_data  = logits[i];
            tick();
        end
        in_valid = 1'b0;
        in_data  = 32'd0;
        chk("in_ready_after_load", in_ready, 0);
        for (int k = 0; k < 10; k++) begin
            chk("div_start", div_start, 1);
            num = div_num;
            den = div_den;
            got_num[k] = num;
            got_den[k] = den;
            chk("div_den", den, esum);
            chk("div_num", num, {e[k], 16'h0000});
            tick();
            chk("div_start_one_cycle", div_start, 0);
            if (k == rst_idx) begin
                #2 rst_n = 1'b0;
                #1 chk_all_zero("rst_mid");
                @(posedge clk);
                #1;
                rst_n    = 1'b1;
                div_done = 1'b1;
                div_quot = 32'h1234_5678;
                tick();
                div_done = 1'b0;
                div_quot = 32'd0;
                chk("post_rst_in_ready", in_ready, 1);
                chk("post_rst_out_valid", out_valid, 0);
                chk("post_rst_out_data", out_data, 0);
                return;
            end
            tick();
            tick();
            chk("div_num_hold", div_num, num);
            chk("div_den_hold", div_den, den);
            q = (den == 36'd0) ? 48'd0 : num / {12'd0, den};
            div_quot = q[31:0];
            div_done = 1'b1;
            if (k == hold_idx)
                out_ready = 1'b0;
            tick();
            div_done = 1'b0;
            div_quot = 32'd0;
            qexp = {e[k], 16'h0000} / {12'd0, esum};
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, qexp[31:0]);
            chk("out_idx", out_idx, k);
            chk("out_last", out_last, (k == 9));
            chk("argmax", argmax, amax);
            got_quot[k] = out_data;
            if (k == 0)
                got_arg = argmax;
            if (k == hold_idx) begin
                for (int h = 0; h < 5; h++) begin
                    tick();
                    chk("hold_out_valid", out_valid, 1);
                    chk("hold_out_data", out_data, qexp[31:0]);
                    chk("hold_out_idx", out_idx, k);
                    chk("hold_no_div_start", div_start, 0);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        chk("end_out_valid", out_valid, 0);
        chk("end_in_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        div_done  = 1'b0;
        div_quot  = 32'd0;
        out_ready = 1'b1;
        #3 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("first_in_ready", in_ready, 1);

        // All logits zero: every E=1, sum 10, 65536/10 = 6553
        for (int i = 0; i < 10; i++) logits[i] = 32'd0;
        run_set(-1, -1);
        chk("zeros_den", got_den[0], 36'd10);
        chk("zeros_quot0", got_quot[0], 32'd6553);
        chk("zeros_quot5", got_quot[5], 32'd6553);
        chk("zeros_quot9", got_quot[9], 32'd6553);

        // Logits 0..9: sum 1023
        for (int i = 0; i < 10; i++) logits[i] = i;
        run_set(-1, -1);
        chk("ramp_den", got_den[9], 36'd1023);
        chk("ramp_num9", got_num[9], 48'd33554432);
        chk("ramp_quot9", got_quot[9], 32'd32800);
        chk("ramp_quot0", got_quot[0], 32'd64);
`ifdef SOFTMAX_SEQ_ARGMAX_EN
        chk("ramp_argmax", got_arg, 4'd9);
`else
        chk("ramp_argmax", got_arg, 4'd0);
`endif

        // Clamped exponent on beat 0, back-pressure on class 3
        for (int i = 0; i < 10; i++) logits[i] = 32'd0;
        logits[0] = 32'd40;
        run_set(3, -1);
        chk("clamp_den", got_den[0], 36'h0_8000_0009);
        chk("clamp_num0", got_num[0], 48'h8000_0000_0000);
        chk("clamp_quot0", got_quot[0], 32'd65535);
        chk("clamp_quot1", got_quot[1], 32'd0);

        // Logits 5,7,7,2,0...: reset during class 4, then the same set again
        for (int i = 0; i < 10; i++) logits[i] = 32'd0;
        logits[0] = 32'd5;
        logits[1] = 32'd7;
        logits[2] = 32'd7;
        logits[3] = 32'd2;
        run_set(-1, 4);
        tick();
        chk("stale_done_out_valid", out_valid, 0);
        chk("stale_done_in_ready", in_ready, 1);
        run_set(-1, -1);
        chk("tie_den", got_den[0], 36'd298);
        chk("tie_quot0", got_quot[0], 32'd7037);
        chk("tie_quot1", got_quot[1], 32'd28149);
`ifdef SOFTMAX_SEQ_ARGMAX_EN
        chk("tie_argmax", got_arg, 4'd1);
`else
        chk("tie_argmax", got_arg, 4'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/softmax_seq.md
SOFTMAX_SEQ -- requirements
Module: softmax_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 in_valid  input  1  logit word valid.
REQ-004 in_ready  output  1  block accepts a logit this cycle.
REQ-005 in_data  input  32  unsigned logit exponent.
REQ-006 div_start  output  1  one-cycle request to the shared divider.
REQ-007 div_num  output  48  dividend, {E[idx], 16'h0000}, held stable from div_start until div_done.
REQ-008 div_den  output  36  divisor, the exponent sum, held stable from div_start until div_done.
REQ-009 div_done  input  1  one-cycle divider completion pulse.
REQ-010 div_quot  input  32  divider quotient, valid with div_done.
REQ-011 out_valid  output  1  probability word valid.
REQ-012 out_ready  input  1  downstream accepts the word.
REQ-013 out_data  output  32  probability, unsigned Q16.16.
REQ-014 out_idx  output  4  class index 0..9 of out_data.
REQ-015 out_last  output  1  high with idx 9.
REQ-016 argmax  output  4  index of the largest logit; valid while out_valid=1.

Function
REQ-017 States: IDLE, LOAD, DIV_REQ, DIV_WAIT, OUT.
- IDLE goes to LOAD immediately.
- in_ready=1 only in LOAD.
REQ-018 LOAD
- Each in_valid&in_ready beat stores E[cnt] = 1<<in_data when in_data<31, else 32'h8000_0000 (clamp).
- The same beat adds E[cnt] to the 36-bit sum; cnt increments.
- Sum cleared on entry to LOAD.
REQ-019 After the 10th accepted beat (cnt=9), go to DIV_REQ with idx=0. No beat is accepted on the transition cycle.
REQ-020 DIV_REQ
- div_start=1 for exactly one cycle with div_num/div_den for idx, then go to DIV_WAIT.
REQ-021 DIV_WAIT
- On div_done, capture div_quot into out_data, set out_valid=1, go to OUT.
- div_done in any other state is ignored.
REQ-022 OUT
- Hold out_valid, out_data, out_idx stable until out_ready=1.
- On acceptance with idx<9: idx+1, go to DIV_REQ.
- On acceptance with idx=9: go to LOAD (cnt=0, sum=0).
REQ-023 Latency: the first div_start occurs 1 cycle after the 10th input beat. The next div_start occurs 1 cycle after each accepted output.
REQ-024 Quotient is passed through unchanged; rounding is the divider's truncation.
REQ-025 Sum arithmetic
- Sum never overflows: max 10*2^31 < 2^36.
- div_den is never 0, since every E>=1.

Reset
REQ-026 On rst_n=0, asynchronously set the following:
- state=IDLE, cnt=0, idx=0, sum=0.
- in_ready=0, div_start=0, out_valid=0, out_data=0, out_idx=0, out_last=0, argmax=0.
REQ-027 Reset in any state, including DIV_WAIT, discards stored logits and the partial sum.
REQ-028 A div_done arriving after reset deassertion before a new div_start is ignored.
REQ-029 Stored E registers need no reset.

Configuration
REQ-030 Macro SOFTMAX_SEQ_ARGMAX_EN.
- Defined: track the maximum clamped logit during LOAD (strict greater-than, so the lowest index wins ties) and drive argmax from a register updated at the end of LOAD.
- Undefined: argmax is tied to 4'd0 and no comparator is built.
- All other behaviour is identical in both builds.

Verification
REQ-031 Ten logits of 0, divider model 3 cycles, out_ready=1 -> div_den=10 every request; out_data=6553 for idx 0..9; out_last on idx 9 only.
REQ-032 Logits 0,1,...,9 -> div_den=1023; idx9 div_num=512<<16 and out_data=32800; idx0 out_data=64. With macro: argmax=9.
REQ-033 out_ready held 0 for 5 cycles on idx 3 -> out_valid/out_data/out_idx stable; no div_start until acceptance; div_start 1 cycle after acceptance.
REQ-034 in_data=40 on beat 0, other beats 0 -> E[0]=32'h8000_0000; div_den=36'h0_8000_0009; no wrap.
REQ-035 rst_n pulsed low during DIV_WAIT of idx 4, then a stale div_done -> all outputs 0 immediately; stale div_done ignored; in_ready=1 one cycle after rst_n rises; next set processes normally.
REQ-036 Logits 5,7,7,2,... (max 7) with macro -> argmax=1; without macro -> argmax=0.
